// File: rtl/regfile_read_port_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port_pkg
//  Description : Constants shared by the register-file read port, the bit-cell
//                array and the write-port logic.
//                  WIDTH    - data bits per register (bitline bus width)
//                  NREGS    - number of register rows
//                  ADDR_W   - register address width (NREGS == 2**ADDR_W)
//                  REG_ZERO - index of the hardwired-zero register
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_read_port_pkg;

    localparam int WIDTH    = 16;
    localparam int NREGS    = 16;
    localparam int ADDR_W   = 4;
    localparam int REG_ZERO = 0;

endpackage : regfile_read_port_pkg
`default_nettype wire

// File: rtl/regfile_read_port_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : read_decoder
//  Description : Address to one-hot read-wordline decoder for one read port.
//                The hardwired-zero row never gets a wordline, so its bitline
//                driver stays off and the bus floats for that address.
//  Ports       : i_en       - drive a wordline this cycle
//                i_addr     - row address
//                o_wordline - one-hot ReadEnable per row (all zero when idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module read_decoder #(
    parameter int ADDR_W = regfile_read_port_pkg::ADDR_W,
    parameter int NREGS  = regfile_read_port_pkg::NREGS
) (
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [NREGS-1:0]  o_wordline
);

    import regfile_read_port_pkg::*;

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_row
            if (g == REG_ZERO) begin : g_zero
                assign o_wordline[g] = 1'b0;
            end else begin : g_cell
                assign o_wordline[g] = i_en && (i_addr == ADDR_W'(g));
            end
        end
    endgenerate

endmodule : read_decoder
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port
//  Description : Read-side controller for the bit-cell register array.
//                Two-stage pipeline:
//                  RD  - holds the latched source addresses and drives the
//                        one-hot read wordlines into the array.
//                  RSP - registered response data with valid/ready.
//                Data is captured from the shared bitline buses on the edge
//                where RD advances into RSP. The cells do not bypass, so a
//                write landing on that same edge is forwarded from wr_data.
//  Ports       : clk                  - clock, rising edge
//                rst                  - asynchronous reset, active low
//                req_valid/req_ready  - request handshake
//                req_addr1/req_addr2  - source registers for port 1/2
//                wordline1/wordline2  - one-hot ReadEnable1/ReadEnable2 rows
//                bitline1/bitline2    - shared read bitline buses
//                wr_en/wr_addr/wr_data- array write occurring this cycle
//                rsp_valid/rsp_ready  - response handshake
//                rsp_data1/rsp_data2  - read data for port 1/2
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port #(
    parameter int WIDTH  = regfile_read_port_pkg::WIDTH,
    parameter int NREGS  = regfile_read_port_pkg::NREGS,
    parameter int ADDR_W = regfile_read_port_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    output logic [NREGS-1:0]  wordline1,
    output logic [NREGS-1:0]  wordline2,
    input  logic [WIDTH-1:0]  bitline1,
    input  logic [WIDTH-1:0]  bitline2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WIDTH-1:0]  rsp_data1,
    output logic [WIDTH-1:0]  rsp_data2
);

    import regfile_read_port_pkg::*;

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(REG_ZERO);

    // RD stage
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_addr1;
    logic [ADDR_W-1:0] r_rd_addr2;

    // RSP stage
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_data1;
    logic [WIDTH-1:0]  r_rsp_data2;

    // Handshake
    logic              w_rsp_adv;
    logic              w_rd_adv;
    logic              w_req_fire;

    // Per-port capture values
    logic [WIDTH-1:0]  w_cap1;
    logic [WIDTH-1:0]  w_cap2;

    assign w_rsp_adv  = !r_rsp_valid || rsp_ready;
    assign w_rd_adv   = r_rd_valid && w_rsp_adv;
    assign req_ready  = !r_rd_valid || w_rd_adv;
    assign w_req_fire = req_valid && req_ready;

    // Wordlines follow r_rd_valid directly, so an asynchronous reset drops
    // them immediately and a stalled RD keeps them asserted.
    read_decoder #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_dec1 (
        .i_en       (r_rd_valid),
        .i_addr     (r_rd_addr1),
        .o_wordline (wordline1)
    );

    read_decoder #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_dec2 (
        .i_en       (r_rd_valid),
        .i_addr     (r_rd_addr2),
        .o_wordline (wordline2)
    );

    // Capture mux. Register zero wins over everything: its bitline is never
    // driven and a write to it must not leak through the bypass. A write to
    // the addressed row on the capture edge is not yet visible on the
    // bitline, so it is forwarded from wr_data.
    always_comb begin
        w_cap1 = bitline1;
        if (wr_en && (wr_addr == r_rd_addr1)) begin
            w_cap1 = wr_data;
        end
        if (r_rd_addr1 == c_zero_addr) begin
            w_cap1 = '0;
        end
    end

    always_comb begin
        w_cap2 = bitline2;
        if (wr_en && (wr_addr == r_rd_addr2)) begin
            w_cap2 = wr_data;
        end
        if (r_rd_addr2 == c_zero_addr) begin
            w_cap2 = '0;
        end
    end

    // RD stage: load on accept, empty when the entry moves on without a
    // replacement, otherwise hold (stall keeps addresses and wordlines).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_valid <= 1'b0;
            r_rd_addr1 <= '0;
            r_rd_addr2 <= '0;
        end else begin
            if (w_req_fire) begin
                r_rd_valid <= 1'b1;
                r_rd_addr1 <= req_addr1;
                r_rd_addr2 <= req_addr2;
            end else if (w_rd_adv) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    // RSP stage: whenever it may advance it takes whatever RD holds; the data
    // registers only load when RD actually carries a request, so a stall
    // redoes the capture on the eventual advancing edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data1 <= '0;
            r_rsp_data2 <= '0;
        end else begin
            if (w_rsp_adv) begin
                r_rsp_valid <= r_rd_valid;
                if (r_rd_valid) begin
                    r_rsp_data1 <= w_cap1;
                    r_rsp_data2 <= w_cap2;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data1 = r_rsp_data1;
    assign rsp_data2 = r_rsp_data2;

endmodule : regfile_read_port
`default_nettype wire

// File: tb/tb_regfile_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_read_port
//  Description : Testbench for regfile_read_port. Contains a behavioural model
//                of the register array (tri-state bitlines, write port) and a
//                scoreboard: accepted requests are queued, and a monitor
//                resolves each response against the array contents at the
//                moment the response appears, then checks it at handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_read_port;

    import regfile_read_port_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr1;
    logic [ADDR_W-1:0] req_addr2;
    logic [NREGS-1:0]  wordline1;
    logic [NREGS-1:0]  wordline2;
    wire  [WIDTH-1:0]  bitline1;
    wire  [WIDTH-1:0]  bitline2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_data1;
    logic [WIDTH-1:0]  rsp_data2;

    regfile_read_port u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr1 (req_addr1),
        .req_addr2 (req_addr2),
        .wordline1 (wordline1),
        .wordline2 (wordline2),
        .bitline1  (bitline1),
        .bitline2  (bitline2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data1 (rsp_data1),
        .rsp_data2 (rsp_data2)
    );

    always #5 clk = ~clk;

    // ---------------- register array model ----------------
    logic [WIDTH-1:0] mem [NREGS];

    function automatic int hot_idx(input logic [NREGS-1:0] wl);
        hot_idx = 0;
        for (int i = 0; i < NREGS; i++) if (wl[i]) hot_idx = i;
    endfunction

    assign bitline1 = (wordline1 != '0) ? mem[hot_idx(wordline1)] : 'z;
    assign bitline2 = (wordline2 != '0) ? mem[hot_idx(wordline2)] : 'z;

    always @(posedge clk) begin
        if (wr_en && wr_addr != 4'd0) mem[wr_addr] <= wr_data;
    end

    function automatic logic [WIDTH-1:0] reg_val(input logic [ADDR_W-1:0] a);
        reg_val = (a == 4'd0) ? 16'h0000 : mem[a];
    endfunction

    function automatic logic [NREGS-1:0] onehot(input logic [ADDR_W-1:0] a);
        onehot = (a == 4'd0) ? 16'h0000 : (16'h0001 << a);
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [ADDR_W-1:0] a1;
        logic [ADDR_W-1:0] a2;
    } req_t;

    req_t q_rd[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic need_new = 1'b1;
    logic [WIDTH-1:0] exp1, exp2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle sampling. A response appearing for the first time
    // was captured at the previous rising edge, so its expected value is the
    // array content right after that edge (including a write on that edge).
    always @(negedge clk) begin
        if (rst) begin
            if (rsp_valid && need_new) begin
                if (q_rd.size() == 0) begin
                    chk("spurious_rsp", 32'd1, 32'd0);
                end else begin
                    req_t it;
                    it = q_rd.pop_front();
                    exp1 = reg_val(it.a1);
                    exp2 = reg_val(it.a2);
                    need_new = 1'b0;
                end
            end else if (!rsp_valid && !need_new) begin
                chk("rsp_dropped", 32'd0, 32'd1);
                need_new = 1'b1;
            end
            chk("mon_wordline1", wordline1, (q_rd.size() != 0) ? onehot(q_rd[0].a1) : 16'h0000);
            chk("mon_wordline2", wordline2, (q_rd.size() != 0) ? onehot(q_rd[0].a2) : 16'h0000);
            if (rsp_valid && !need_new) begin
                chk("mon_rsp_data1", rsp_data1, exp1);
                chk("mon_rsp_data2", rsp_data2, exp2);
                if (rsp_ready) need_new = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    // One cycle of stimulus: drive just after the rising edge, then report
    // (mid-cycle) whether the request will be accepted at the next edge.
    task automatic step(input logic rv, input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                        input logic we, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                        input logic rr, output logic acc);
        @(posedge clk);
        #1;
        req_valid = rv;
        req_addr1 = a1;
        req_addr2 = a2;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        rsp_ready = rr;
        @(negedge clk);
        #1;
        acc = rv && req_ready && rst;
        if (acc) q_rd.push_back('{a1: a1, a2: a2});
    endtask

    task automatic idle(input logic rr, output logic acc);
        step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, rr, acc);
    endtask

    logic             acc;
    logic [WIDTH-1:0] r5v;
    logic [WIDTH-1:0] wd;
    int               cnt, hs, run, maxrun;
    logic             has;
    logic [ADDR_W-1:0] p1, p2, wa;
    logic             we, rr;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr1 = '0; req_addr2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_wordline1", wordline1, 16'h0000);
        chk("reset_wordline2", wordline2, 16'h0000);
        chk("reset_rsp_data1", rsp_data1, 16'h0000);
        chk("reset_rsp_data2", rsp_data2, 16'h0000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 chk("reset_req_ready", req_ready, 1);

        // Preload the array through its write port
        r5v = 16'h5A3C;
        for (int r = 1; r < NREGS; r++) begin
            case (r)
                3:       wd = 16'hBEEF;
                4:       wd = 16'h0000;
                5:       wd = r5v;
                7:       wd = 16'h1234;
                default: wd = 16'($urandom);
            endcase
            step(1'b0, 4'd0, 4'd0, 1'b1, 4'(r), wd, 1'b1, acc);
        end
        idle(1'b1, acc);

        // Basic read (3,7): wordlines in cycle N+1, response after N+1
        step(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 16'h0, 1'b1, acc);
        chk("basic_accept", acc, 1);
        idle(1'b1, acc);
        chk("basic_wordline1", wordline1, 16'h0008);
        chk("basic_wordline2", wordline2, 16'h0080);
        chk("basic_not_early", rsp_valid, 0);
        idle(1'b1, acc);
        chk("basic_rsp_valid", rsp_valid, 1);
        chk("basic_rsp_data1", rsp_data1, 16'hBEEF);
        chk("basic_rsp_data2", rsp_data2, 16'h1234);

        // Zero register with a floating bitline
        step(1'b1, 4'd0, 4'd5, 1'b0, 4'd0, 16'h0, 1'b1, acc);
        idle(1'b1, acc);
        chk("zero_wordline1", wordline1, 16'h0000);
        chk("zero_wordline2", wordline2, 16'h0020);
        idle(1'b1, acc);
        chk("zero_rsp_data1", rsp_data1, 16'h0000);
        chk("zero_rsp_data2", rsp_data2, r5v);

        // Bypass: write r4 while (4,4) sits in RD
        step(1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 16'h0, 1'b1, acc);
        step(1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 16'hA5A5, 1'b1, acc);
        idle(1'b1, acc);
        chk("bypass_rsp_data1", rsp_data1, 16'hA5A5);
        chk("bypass_rsp_data2", rsp_data2, 16'hA5A5);

        // Backpressure: three requests, consumer stalled for 4 cycles,
        // r3 rewritten while the second request waits in RD
        cnt = 0;
        step(1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 16'h0, 1'b0, acc); cnt += int'(acc);
        step(1'b1, 4'd3, 4'd6, 1'b0, 4'd0, 16'h0, 1'b0, acc); cnt += int'(acc);
        chk("bp_two_accepts", cnt, 2);
        step(1'b1, 4'd8, 4'd9, 1'b1, 4'd3, 16'h0F0F, 1'b0, acc);
        chk("bp_req_ready_low", req_ready, 0);
        chk("bp_rsp_held", rsp_valid, 1);
        has = !acc;
        step(has, 4'd8, 4'd9, 1'b0, 4'd0, 16'h0, 1'b0, acc);
        if (acc) has = 1'b0;
        hs = 0;
        for (int k = 0; k < 8; k++) begin
            step(has, 4'd8, 4'd9, 1'b0, 4'd0, 16'h0, 1'b1, acc);
            if (acc) has = 1'b0;
            if (rsp_valid && rsp_ready) begin
                hs++;
                if (hs == 2) chk("bp_stall_write_seen", rsp_data1, 16'h0F0F);
            end
        end
        chk("bp_third_accepted", has, 0);
        chk("bp_three_responses", hs, 3);

        // Streaming: one request per cycle over all addresses
        cnt = 0; hs = 0; run = 0; maxrun = 0;
        for (int i = 0; i < 19; i++) begin
            if (i < 16) step(1'b1, 4'(i), 4'(15 - i), 1'b0, 4'd0, 16'h0, 1'b1, acc);
            else        idle(1'b1, acc);
            cnt += int'(acc);
            if (rsp_valid && rsp_ready) begin hs++; run++; end
            else run = 0;
            if (run > maxrun) maxrun = run;
        end
        chk("stream_accepts", cnt, 16);
        chk("stream_responses", hs, 16);
        chk("stream_consecutive", maxrun, 16);

        // Randomized traffic with writes and backpressure
        has = 1'b0; p1 = '0; p2 = '0;
        for (int n = 0; n < 400; n++) begin
            if (!has && ($urandom_range(0, 3) != 0)) begin
                has = 1'b1;
                p1 = 4'($urandom_range(0, 15));
                p2 = ($urandom_range(0, 3) == 0) ? p1 : 4'($urandom_range(0, 15));
            end
            we = ($urandom_range(0, 2) == 0);
            wa = ($urandom_range(0, 1) == 0) ? p1 : 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 3) != 0);
            step(has, p1, p2, we, wa, 16'($urandom), rr, acc);
            if (acc) has = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            step(has, p1, p2, 1'b0, 4'd0, 16'h0, 1'b1, acc);
            if (acc) has = 1'b0;
        end
        chk("rand_all_issued", has, 0);

        // Reset mid-operation with both stages full
        step(1'b1, 4'd2, 4'd3, 1'b0, 4'd0, 16'h0, 1'b0, acc);
        step(1'b1, 4'd5, 4'd6, 1'b0, 4'd0, 16'h0, 1'b0, acc);
        step(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, acc);
        chk("midrst_wordline_before", wordline1, 16'h0020);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_wordline1", wordline1, 16'h0000);
        chk("midrst_wordline2", wordline2, 16'h0000);
        q_rd.delete();
        need_new = 1'b1;
        idle(1'b1, acc);
        idle(1'b1, acc);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 chk("midrst_req_ready", req_ready, 1);

        // Traffic after reset recovery
        has = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (!has) begin
                has = 1'b1;
                p1 = 4'($urandom_range(0, 15));
                p2 = 4'($urandom_range(0, 15));
            end
            step(has, p1, p2, 1'b0, 4'd0, 16'h0, ($urandom_range(0, 2) != 0), acc);
            if (acc) has = 1'b0;
        end
        for (int i = 0; i < 8; i++) begin
            step(has, p1, p2, 1'b0, 4'd0, 16'h0, 1'b1, acc);
            if (acc) has = 1'b0;
        end
        chk("drain_pending_requests", q_rd.size(), 0);
        chk("drain_no_open_response", need_new, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_read_port
`default_nettype wire
